// File: rtl/beam_scan_doa.sv
// beam_scan_doa: steps a steering angle, measures beamformer energy per angle and reports the peak.
module beam_scan_doa #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int ANGLE_STEP     = 1,
  parameter int MAX_ANGLE      = 180,
  parameter int SETTLE_SAMPLES = 16,
  parameter int DWELL_LOG2     = 10,
  parameter int ACC_WIDTH      = 2*SAMPLE_WIDTH+DWELL_LOG2
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           start_in,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid_in,
  output logic [7:0]                     angle_out,
  output logic                           busy_out,
  output logic                           energy_valid_out,
  output logic [ACC_WIDTH-1:0]           energy_out,
  output logic                           done_out,
  output logic [7:0]                     best_angle_out,
  output logic [ACC_WIDTH-1:0]           best_energy_out
);
  localparam int DWELL = 1 << DWELL_LOG2;
  localparam int CMAX  = SETTLE_SAMPLES > DWELL ? SETTLE_SAMPLES : DWELL;
  localparam int CW    = $clog2(CMAX);
  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, COMPARE, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]                   r_cnt;
  logic [ACC_WIDTH-1:0]            r_acc, r_best_e, r_energy, r_best_e_out;
  logic [7:0]                      r_angle, r_best_a, r_best_a_out;
  logic                            r_busy, r_done, r_energy_valid;
  logic signed [2*SAMPLE_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]            w_acc_sum;
  logic [8:0]                      w_angle_sum;
  logic                            w_settle_end, w_accum_end, w_last_angle, w_upd, w_busy, w_done;
  assign w_prod      = sample_in * sample_in;
  assign w_acc_sum   = r_acc + ACC_WIDTH'($unsigned(w_prod));
  assign w_angle_sum = {1'b0, r_angle} + 9'(ANGLE_STEP);
  assign w_last_angle = w_angle_sum > 9'(MAX_ANGLE);
  assign w_settle_end = r_state == SETTLE && sample_valid_in && r_cnt == CW'(SETTLE_SAMPLES-1);
  assign w_accum_end  = r_state == ACCUM && sample_valid_in && r_cnt == CW'(DWELL-1);
  assign w_upd        = r_acc > r_best_e;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start_in ? SETTLE : IDLE;
      SETTLE:  w_next = w_settle_end ? ACCUM : SETTLE;
      ACCUM:   w_next = w_accum_end ? COMPARE : ACCUM;
      COMPARE: w_next = w_last_angle ? DONE : SETTLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // outputs are registered from the next state so done and busy-fall share one cycle
  always_comb begin
    w_busy = w_next == SETTLE || w_next == ACCUM || w_next == COMPARE;
    w_done = w_next == DONE;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt          <= '0;
      r_acc          <= '0;
      r_best_e       <= '0;
      r_best_a       <= '0;
      r_angle        <= '0;
      r_energy       <= '0;
      r_best_e_out   <= '0;
      r_best_a_out   <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_energy_valid <= 1'b0;
    end else begin
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_energy_valid <= w_accum_end;
      if (w_accum_end) r_energy <= w_acc_sum;
      unique case (r_state)
        IDLE: if (start_in) begin
          r_angle  <= '0;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_best_e <= '0;
          r_best_a <= '0;
        end
        SETTLE: if (sample_valid_in) begin
          r_cnt <= w_settle_end ? '0 : r_cnt + 1'b1;
          if (w_settle_end) r_acc <= '0;
        end
        ACCUM: if (sample_valid_in) begin
          r_acc <= w_acc_sum;
          r_cnt <= w_accum_end ? '0 : r_cnt + 1'b1;
        end
        COMPARE: begin
          if (w_upd) begin
            r_best_e <= r_acc;
            r_best_a <= r_angle;
          end
          if (!w_last_angle) r_angle <= w_angle_sum[7:0];
          if (w_last_angle) begin
            r_best_e_out <= w_upd ? r_acc : r_best_e;
            r_best_a_out <= w_upd ? r_angle : r_best_a;
          end
        end
        default: ;
      endcase
    end
  end
  assign angle_out        = r_angle;
  assign busy_out         = r_busy;
  assign energy_valid_out = r_energy_valid;
  assign energy_out       = r_energy;
  assign done_out         = r_done;
  assign best_angle_out   = r_best_a_out;
  assign best_energy_out  = r_best_e_out;
endmodule
